// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data_memory port arbiter between the CPU and the equalizer accelerator
// Optional build macro DMEM_ARB_STATS_EN adds saturating activity counters.
module dmem_arbiter #(
   parameter int DW           = 32,
   parameter int AW           = 32,
   parameter int MAX_BURST    = 16,
   parameter int STARVE_LIMIT = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          acc_req,
   input  logic          acc_we,
   input  logic [AW-1:0] acc_addr,
   input  logic [DW-1:0] acc_wdata,
   input  logic          acc_last,
   output logic          acc_gnt,
   output logic [DW-1:0] acc_rdata,
   output logic          acc_rvalid,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0]   stat_acc_beats,
   output logic [31:0]   stat_cpu_stalls,
   output logic [15:0]   stat_forced
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_YIELD} state_t;

   localparam logic [7:0] MAX_B    = 8'(MAX_BURST);
   localparam logic [7:0] STARVE_L = 8'(STARVE_LIMIT);

   state_t     state_q, state_d;
   logic [7:0] beat_q, beat_d;
   logic [7:0] starve_q, starve_d;
   logic       cpu_gnt, acc_gnt_w, forced;

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      cpu_gnt   = 1'b0;
      acc_gnt_w = 1'b0;
      forced    = 1'b0;
      case (state_q)
         S_IDLE: begin
            beat_d = 8'd0;
            if (acc_req && starve_q == STARVE_L) begin
               forced    = 1'b1;
               acc_gnt_w = 1'b1;
            end else if (cpu_req) begin
               cpu_gnt = 1'b1;
            end else if (acc_req) begin
               acc_gnt_w = 1'b1;
            end
            if (acc_gnt_w && !acc_last) begin
               state_d = S_BURST;
               beat_d  = 8'd1;
            end
         end
         S_BURST: begin
            if (acc_req) begin
               acc_gnt_w = 1'b1;
               beat_d    = beat_q + 8'd1;
               if (acc_last) begin
                  state_d = S_IDLE;
                  beat_d  = 8'd0;
               end else if (beat_q + 8'd1 == MAX_B) begin
                  state_d = S_YIELD;
               end
            end else begin
               // accelerator dropped mid-burst: it must rearbitrate from IDLE
               cpu_gnt = cpu_req;
               state_d = S_IDLE;
               beat_d  = 8'd0;
            end
         end
         S_YIELD: begin
            state_d = S_IDLE;
            beat_d  = 8'd0;
            if (cpu_req) begin
               cpu_gnt = 1'b1;
            end else if (acc_req) begin
               acc_gnt_w = 1'b1;
            end
            if (acc_gnt_w && !acc_last) begin
               state_d = S_BURST;
               beat_d  = 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            beat_d  = 8'd0;
         end
      endcase
      if (reset) begin
         cpu_gnt   = 1'b0;
         acc_gnt_w = 1'b0;
         forced    = 1'b0;
      end
   end

   always_comb begin
      starve_d = 8'd0;
      if (acc_req && !acc_gnt_w) begin
         starve_d = (starve_q >= STARVE_L) ? STARVE_L : starve_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         beat_q   <= 8'd0;
         starve_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         starve_q <= starve_d;
      end
   end

   assign acc_gnt    = acc_gnt_w;
   assign acc_rvalid = acc_gnt_w & ~acc_we;
   assign cpu_stall  = cpu_req & ~cpu_gnt & ~reset;
   assign cpu_rdata  = mem_rdata;
   assign acc_rdata  = mem_rdata;
   assign mem_we     = cpu_gnt ? cpu_we    : (acc_gnt_w ? acc_we    : 1'b0);
   assign mem_addr   = cpu_gnt ? cpu_addr  : (acc_gnt_w ? acc_addr  : '0);
   assign mem_wdata  = cpu_gnt ? cpu_wdata : (acc_gnt_w ? acc_wdata : '0);

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] acc_beats_q, cpu_stalls_q;
   logic [15:0] forced_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_beats_q  <= 32'd0;
         cpu_stalls_q <= 32'd0;
         forced_q     <= 16'd0;
      end else begin
         if (acc_gnt_w && acc_beats_q != 32'hFFFF_FFFF) acc_beats_q <= acc_beats_q + 32'd1;
         if (cpu_stall && cpu_stalls_q != 32'hFFFF_FFFF) cpu_stalls_q <= cpu_stalls_q + 32'd1;
         if (forced && forced_q != 16'hFFFF) forced_q <= forced_q + 16'd1;
      end
   end

   assign stat_acc_beats  = acc_beats_q;
   assign stat_cpu_stalls = cpu_stalls_q;
   assign stat_forced     = forced_q;
`endif

endmodule
